decoder: RTL and testbench
==========================

Name: decoder

Overview:
- Serial bitstream pixel decoder for 8-bit grayscale frames.
- Consumes one code bit per qualified clock, decodes a 3-form prefix code into pixels, and writes each pixel sequentially into an external image RAM.
- Performs a read-modify-write increment of an external histogram RAM bin per pixel.
- Sits between the bitstream source and the image/histogram memories.

Parameters:
- IMAGE_WIDTH, 320, pixels per line.
- IMAGE_HEIGHT, 240, lines per frame.
- PIXEL_WIDTH, 8, bits per pixel.
- TABLE_SIZE, 64, entries in the literal cache table; power of 2; index width = clog2(TABLE_SIZE) = 6.
- IMAGE_RAM_ADDRESS_WIDTH, 17, clog2(IMAGE_WIDTH*IMAGE_HEIGHT).
- HISTOGRAM_RAM_ADDRESS_WIDTH, 8, equals PIXEL_WIDTH.
- HISTOGRAM_RAM_DATA_WIDTH, 17, bin counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- bit  in  1  serial code bit.
- is_new  in  1  bit is valid this cycle.
- histogram_RAM_data  inout  HISTOGRAM_RAM_DATA_WIDTH  read data from RAM when WE=0; driven by block when WE=1, high-Z otherwise.
- histogram_RAM_address  out  HISTOGRAM_RAM_ADDRESS_WIDTH  bin address.
- histogram_RAM_WE  out  1  histogram write enable.
- image_RAM_address  out  IMAGE_RAM_ADDRESS_WIDTH  pixel address.
- image_RAM_data  out  PIXEL_WIDTH  pixel value.
- image_RAM_WE  out  1  image write enable, one-cycle pulse.

Behaviour:
- One clock, clk; reset rst is asynchronous and active-high.
- Reset values: all outputs 0; WE lines 0; histogram data port high-Z; prev_pixel=0; cache table all 0; cache write pointer 0; pixel counter 0; bit decoder in IDLE.
- A bit is accepted at a rising edge only when is_new=1. Cycles with is_new=0 are ignored and the decoder holds its state; gaps are allowed mid-code.
- Code forms, MSB first:
  - "00" -> pixel = prev_pixel.
  - "01" + 6-bit index -> pixel = table[index].
  - "1" + 8-bit literal -> pixel = literal; table[wptr] <= literal; wptr <= wptr+1 mod TABLE_SIZE.
- After each pixel, prev_pixel <= pixel.
- Decoder FSM states: IDLE (expect first bit), PFX2 (second prefix bit), IDX (6 bits), LIT (8 bits). Return to IDLE after the last bit of a code.
- Let edge E be the edge at which the last bit of a code is accepted.
  - Cycle after E (C1):
    - image_RAM_WE=1, image_RAM_address=counter, image_RAM_data=pixel.
    - histogram_RAM_address=pixel, histogram_RAM_WE=0.
    - histogram_RAM_data is sampled at the end-of-C1 edge.
  - Next cycle (C2):
    - histogram_RAM_WE=1, histogram_RAM_address=pixel.
    - histogram_RAM_data driven with sampled+1, saturating at all-ones.
    - image_RAM_WE=0.
  - After C2: WE=0, data port high-Z, addresses hold their last values.
- Minimum code length is 2 bits, so C1/C2 of consecutive pixels never overlap. A back-to-back read of the same bin sees the already-written value; the RAM is assumed to write synchronously.
- The pixel counter increments after C1.
- At IMAGE_WIDTH*IMAGE_HEIGHT-1 the counter wraps to 0. On this frame wrap, prev_pixel, table and wptr are cleared; histogram contents are not.
- Histogram RAM is cleared externally; this block never initialises it.
- Reset mid-code or mid-update: the partial code or pending write is discarded, with no spurious WE pulse.

Decomposition:
- Shared package decoder_pkg:
  - prefix constants: PFX_REPEAT=2'b00, PFX_TABLE=2'b01, PFX_LITERAL=1'b1;
  - FSM state typedef {IDLE, PFX2, IDX, LIT};
  - width helper constants.
- One sub-module, histogram_updater. It owns the C1/C2 read-modify-write sequence, the tristate control and saturation. Input is a pixel-valid strobe plus the pixel value.

Test Plan:
- Reset, then bit=0, is_new=1 continuously; RAM returns 1 on reads.
  - Image writes of data 0 at addresses 0,1,2,... every 2 cycles.
  - Histogram read at address 0, then write of 2 at address 0 with WE=1 in the following cycle.
- Literal stream "1"+0xA5.
  - Image write 0xA5 at address 0.
  - Histogram addr 0xA5 read/write.
  - "01"+000000 then yields 0xA5; "00" yields 0xA5.
- 65 literals 0..64, then "01"+000000.
  - Pixel 64: the table wraps, and entry 0 is overwritten.
- is_new toggling 1/0 during a literal code.
  - Decoded value is identical to the gap-free case; pixel write occurs one cycle after the 9th accepted bit.
- RAM returns all-ones on read -> write data stays all-ones (saturation).
- Assert rst between the 4th and 5th literal bits.
  - No WE pulses; outputs are 0.
  - The next full code decodes correctly to address 0.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared constants and types for the serial pixel decoder.
// The prefix-code constants and the bit-decoder state type are defined here.
package decoder_pkg;

    localparam int IMAGE_WIDTH                 = 320;
    localparam int IMAGE_HEIGHT                = 240;
    localparam int PIXEL_WIDTH                 = 8;
    localparam int TABLE_SIZE                  = 64;
    localparam int INDEX_WIDTH                 = $clog2(TABLE_SIZE);
    localparam int IMAGE_RAM_ADDRESS_WIDTH     = 17;
    localparam int HISTOGRAM_RAM_ADDRESS_WIDTH = PIXEL_WIDTH;
    localparam int HISTOGRAM_RAM_DATA_WIDTH    = 17;
    localparam int FRAME_PIXELS                = IMAGE_WIDTH * IMAGE_HEIGHT;

    localparam logic [1:0] PFX_REPEAT  = 2'b00;
    localparam logic [1:0] PFX_TABLE   = 2'b01;
    localparam logic       PFX_LITERAL = 1'b1;

    typedef enum logic [1:0] {IDLE, PFX2, IDX, LIT} state_t;

endpackage

// File: rtl/decoder_histogram_updater.sv
// Read-modify-write of one histogram bin per decoded pixel: address in C1,
// saturating increment driven onto the shared data bus in C2.
module histogram_updater
    import decoder_pkg::*;
#(
    parameter int AW = HISTOGRAM_RAM_ADDRESS_WIDTH,
    parameter int DW = HISTOGRAM_RAM_DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_vld,
    input  logic [AW-1:0] pix,
    inout  wire  [DW-1:0] data,
    output logic [AW-1:0] address,
    output logic          we
);

    logic          rd;
    logic [DW-1:0] wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd      <= 1'b0;
            we      <= 1'b0;
            address <= '0;
            wdata   <= '0;
        end else begin
            rd <= pix_vld;
            we <= rd;
            if (pix_vld)
                address <= pix;
            // Bin counters stick at all-ones rather than wrapping.
            if (rd)
                wdata <= (&data) ? data : data + DW'(1);
        end
    end

    assign data = we ? wdata : 'z;

endmodule

// File: rtl/decoder.sv
// Serial prefix-code pixel decoder: one code bit per is_new cycle, pixels
// written sequentially to image RAM, histogram bin incremented per pixel.
module decoder
    import decoder_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   code_bit,
    input  logic                                   is_new,
    inout  wire  [HISTOGRAM_RAM_DATA_WIDTH-1:0]    histogram_RAM_data,
    output logic [HISTOGRAM_RAM_ADDRESS_WIDTH-1:0] histogram_RAM_address,
    output logic                                   histogram_RAM_WE,
    output logic [IMAGE_RAM_ADDRESS_WIDTH-1:0]     image_RAM_address,
    output logic [PIXEL_WIDTH-1:0]                 image_RAM_data,
    output logic                                   image_RAM_WE
);

    localparam int PW = PIXEL_WIDTH;
    localparam logic [IMAGE_RAM_ADDRESS_WIDTH-1:0] FRAME_LAST =
        IMAGE_RAM_ADDRESS_WIDTH'(FRAME_PIXELS - 1);

    state_t                           state, state_nxt;
    logic [PW-2:0]                    shreg;
    logic [3:0]                       cnt;
    logic [PW-1:0]                    lut [TABLE_SIZE];
    logic [INDEX_WIDTH-1:0]           wptr;
    logic [PW-1:0]                    prev_pixel;
    logic [IMAGE_RAM_ADDRESS_WIDTH-1:0] counter;
    logic                             pix_vld;
    logic                             lit_wr;
    logic [PW-1:0]                    pix;
    logic                             frame_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // pix/pix_vld are valid combinationally on the cycle the last code bit arrives.
    always_comb begin
        state_nxt = state;
        pix_vld   = 1'b0;
        lit_wr    = 1'b0;
        pix       = prev_pixel;
        if (is_new) begin
            case (state)
                IDLE: state_nxt = (code_bit == PFX_LITERAL) ? LIT : PFX2;
                PFX2: begin
                    if ({1'b0, code_bit} == PFX_REPEAT) begin
                        pix_vld   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = IDX;
                    end
                end
                IDX: begin
                    if (cnt == 4'(INDEX_WIDTH - 1)) begin
                        pix_vld   = 1'b1;
                        pix       = lut[{shreg[INDEX_WIDTH-2:0], code_bit}];
                        state_nxt = IDLE;
                    end
                end
                LIT: begin
                    if (cnt == 4'(PW - 1)) begin
                        pix_vld   = 1'b1;
                        lit_wr    = 1'b1;
                        pix       = {shreg, code_bit};
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (is_new) begin
            shreg <= {shreg[PW-3:0], code_bit};
            cnt   <= (state == IDX || state == LIT) ? cnt + 4'd1 : 4'd0;
        end
    end

    // C1 of the last pixel in the frame: restart the frame context.
    assign frame_wrap = image_RAM_WE && (counter == FRAME_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_pixel <= '0;
            wptr       <= '0;
            for (int i = 0; i < TABLE_SIZE; i++) lut[i] <= '0;
        end else if (frame_wrap) begin
            prev_pixel <= '0;
            wptr       <= '0;
            for (int i = 0; i < TABLE_SIZE; i++) lut[i] <= '0;
        end else begin
            if (pix_vld)
                prev_pixel <= pix;
            if (lit_wr) begin
                lut[wptr] <= pix;
                wptr      <= wptr + INDEX_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            image_RAM_WE      <= 1'b0;
            image_RAM_address <= '0;
            image_RAM_data    <= '0;
            counter           <= '0;
        end else begin
            image_RAM_WE <= pix_vld;
            if (pix_vld) begin
                image_RAM_address <= counter;
                image_RAM_data    <= pix;
            end
            if (image_RAM_WE)
                counter <= frame_wrap ? '0 : counter + IMAGE_RAM_ADDRESS_WIDTH'(1);
        end
    end

    histogram_updater #(
        .AW(HISTOGRAM_RAM_ADDRESS_WIDTH),
        .DW(HISTOGRAM_RAM_DATA_WIDTH)
    ) u_hist (
        .clk     (clk),
        .rst     (rst),
        .pix_vld (pix_vld),
        .pix     (pix),
        .data    (histogram_RAM_data),
        .address (histogram_RAM_address),
        .we      (histogram_RAM_WE)
    );

endmodule

// File: tb/tb_decoder.sv
// Directed bench for decoder: logs RAM write events at negedge and compares
// them against hand-computed pixel streams.
module tb_decoder;
    import decoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        code_bit = 1'b0;
    logic        is_new = 1'b0;
    wire  [16:0] h_data;
    logic [16:0] rd_val = '0;
    logic [7:0]  h_addr;
    logic        h_we;
    logic [16:0] i_addr;
    logic [7:0]  i_data;
    logic        i_we;

    decoder dut (
        .clk                   (clk),
        .rst                   (rst),
        .code_bit              (code_bit),
        .is_new                (is_new),
        .histogram_RAM_data    (h_data),
        .histogram_RAM_address (h_addr),
        .histogram_RAM_WE      (h_we),
        .image_RAM_address     (i_addr),
        .image_RAM_data        (i_data),
        .image_RAM_WE          (i_we)
    );

    always #5 clk = ~clk;

    // Histogram RAM stand-in: returns rd_val whenever the decoder is not writing.
    assign h_data = h_we ? 'z : rd_val;

    typedef struct {int edge_n; int addr; int data; int h_addr; int h_we;} ev_t;
    ev_t iw_q[$];
    ev_t hw_q[$];
    int  edge_cnt = 0;
    int  last_acc = 0;
    int  n_tests  = 0;
    int  n_fail   = 0;

    always @(posedge clk) edge_cnt++;

    always @(negedge clk) begin
        if (i_we) iw_q.push_back('{edge_cnt, int'(i_addr), int'(i_data), int'(h_addr), int'(h_we)});
        if (h_we) hw_q.push_back('{edge_cnt, int'(h_addr), int'(h_data), 0, 1});
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(logic [15:0] v, int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            code_bit = v[i];
            is_new   = 1'b1;
            last_acc = edge_cnt + 1;
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            is_new = 1'b0;
        end
    endtask

    task automatic chk_outs_zero(string tag);
        chk({tag, "_iwe"},   i_we,   0);
        chk({tag, "_hwe"},   h_we,   0);
        chk({tag, "_iaddr"}, i_addr, 0);
        chk({tag, "_idata"}, i_data, 0);
        chk({tag, "_haddr"}, h_addr, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        is_new = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        iw_q.delete();
        hw_q.delete();
    endtask

    initial begin
        int e9;

        // Reset state
        @(negedge clk);
        chk_outs_zero("rst");
        do_reset();

        // Continuous zero bits: "00" codes repeat pixel 0 every two cycles
        rd_val = 17'd1;
        send(16'h0, 6);
        idle(4);
        chk("zero_cnt", iw_q.size(), 3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("zero_addr%0d", k), iw_q[k].addr, k);
            chk($sformatf("zero_data%0d", k), iw_q[k].data, 0);
        end
        chk("zero_gap", iw_q[1].edge_n - iw_q[0].edge_n, 2);
        chk("zero_rd_addr", iw_q[0].h_addr, 0);
        chk("zero_rd_we", iw_q[0].h_we, 0);
        chk("zero_hw_cnt", hw_q.size(), 3);
        chk("zero_hw_addr", hw_q[0].addr, 0);
        chk("zero_hw_data", hw_q[0].data, 2);
        chk("zero_hw_edge", hw_q[0].edge_n, iw_q[0].edge_n + 1);
        chk("zero_last_edge", iw_q[2].edge_n, last_acc);

        // Literal A5, then table index 0, then repeat
        do_reset();
        rd_val = 17'd3;
        send(16'h1A5, 9);
        e9 = last_acc;
        send(16'b0100_0000, 8);
        send(16'h0, 2);
        idle(4);
        chk("lit_cnt", iw_q.size(), 3);
        chk("lit_edge", iw_q[0].edge_n, e9);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("lit_addr%0d", k), iw_q[k].addr, k);
            chk($sformatf("lit_data%0d", k), iw_q[k].data, 8'hA5);
        end
        chk("lit_rd_addr", iw_q[0].h_addr, 8'hA5);
        chk("lit_hw_addr", hw_q[0].addr, 8'hA5);
        chk("lit_hw_data", hw_q[0].data, 4);

        // 65 literals wrap the table pointer; entry 0 now holds 64
        do_reset();
        rd_val = 17'd0;
        for (int v = 0; v < 65; v++) send({7'b0, 1'b1, 8'(v)}, 9);
        send(16'b0100_0000, 8);
        send(16'b0100_0001, 8);
        idle(4);
        chk("wrap_cnt", iw_q.size(), 67);
        chk("wrap_lit64", iw_q[64].data, 64);
        chk("wrap_idx0_addr", iw_q[65].addr, 65);
        chk("wrap_idx0_data", iw_q[65].data, 64);
        chk("wrap_idx1_data", iw_q[66].data, 1);
        chk("wrap_hw_data", hw_q[66].data, 1);

        // Gapped literal 0x5C with garbage on the idle cycles
        do_reset();
        rd_val = 17'd5;
        begin
            logic [8:0] code;
            code = 9'h15C;
            for (int i = 8; i >= 0; i--) begin
                @(negedge clk);
                code_bit = code[i];
                is_new   = 1'b1;
                last_acc = edge_cnt + 1;
                @(negedge clk);
                is_new   = 1'b0;
                code_bit = ~code[i];
            end
        end
        idle(4);
        chk("gap_cnt", iw_q.size(), 1);
        chk("gap_data", iw_q[0].data, 8'h5C);
        chk("gap_addr", iw_q[0].addr, 0);
        chk("gap_edge", iw_q[0].edge_n, last_acc);
        chk("gap_hw_data", hw_q[0].data, 6);

        // Saturation at all-ones, and the step just below it
        do_reset();
        rd_val = 17'h1FFFF;
        send(16'h0, 2);
        idle(4);
        chk("sat_ones", hw_q[0].data, 17'h1FFFF);
        rd_val = 17'h1FFFE;
        send(16'h0, 2);
        idle(4);
        chk("sat_below", hw_q[1].data, 17'h1FFFF);

        // Reset between the 4th and 5th literal bits
        do_reset();
        rd_val = 17'd7;
        send(16'b1_0110, 5);
        @(negedge clk);
        rst    = 1'b1;
        is_new = 1'b0;
        @(negedge clk);
        chk_outs_zero("mid");
        rst = 1'b0;
        idle(4);
        chk("mid_no_iwe", iw_q.size(), 0);
        chk("mid_no_hwe", hw_q.size(), 0);
        send(16'h13C, 9);
        idle(4);
        chk("mid_cnt", iw_q.size(), 1);
        chk("mid_addr", iw_q[0].addr, 0);
        chk("mid_data", iw_q[0].data, 8'h3C);
        chk("mid_hw_data", hw_q[0].data, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
